// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_controller
//  Description : Instruction fetch sequencer. Holds the fetch PC, drives the
//                instruction memory address, captures each returned word with
//                its PC into an in-order queue, and presents the queue head to
//                decode over a valid/ready handshake. Trap entry and taken
//                branch/jump redirects flush the queue and restart fetch.
//                Fetches past the end of memory or to a misaligned redirect
//                target halt fetch and raise a sticky fault.
//  Ports       : clk, reset            - clock and synchronous active-high reset
//                imem_pc / imem_inst   - memory address out, same-cycle word in
//                redirect_valid/_pc    - taken branch/jump target
//                trap_valid            - trap entry, restart at TRAP_VEC
//                out_valid/ready/inst/pc - decode handshake (queue head)
//                fetch_fault           - sticky fetch halt indication
//                q_count               - queue occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] TRAP_VEC  = 32'd700,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_pc,
  input  logic [31:0]              imem_inst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     trap_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic                     fetch_fault,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned c_AW = $clog2(DEPTH);
  localparam int unsigned c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
  // Memory limit widened to 33 bits so fpc+4 near 2^32 cannot wrap.
  localparam logic [32:0] c_MEM_LIM = 33'(MEM_BYTES);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fpc;
  logic [31:0]       w_fpc_nxt;
  logic              r_fault;
  logic              w_fault_nxt;
  logic [c_AW-1:0]   r_head;
  logic [c_AW-1:0]   r_tail;
  logic [c_CW-1:0]   r_count;
  logic [31:0]       r_q_pc   [DEPTH];
  logic [31:0]       r_q_inst [DEPTH];

  logic              w_flush;
  logic              w_pop;
  logic              w_push;
  logic              w_in_range;
  logic              w_redir_bad;

  assign w_flush     = trap_valid | redirect_valid;
  // A pop coinciding with a flush is dropped along with the rest of the queue.
  assign w_pop       = out_valid & out_ready & ~w_flush;
  assign w_in_range  = ({1'b0, r_fpc} + 33'd4) <= c_MEM_LIM;
  assign w_redir_bad = (redirect_pc[1:0] != 2'b00) |
                       (({1'b0, redirect_pc} + 33'd4) > c_MEM_LIM);

  // --------------------------------------------------------------------------
  // Next-state / fetch control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_fault_nxt = r_fault;
    w_push      = 1'b0;
    if (trap_valid) begin
      w_state_nxt = ST_RUN;
      w_fpc_nxt   = TRAP_VEC;
      w_fault_nxt = 1'b0;
    end else if (redirect_valid) begin
      w_fpc_nxt = redirect_pc;
      if (w_redir_bad) begin
        w_state_nxt = ST_FAULT;
        w_fault_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_RUN;
        w_fault_nxt = 1'b0;
      end
    end else if (r_state == ST_RUN) begin
      if (!w_in_range) begin
        // Running off the end of memory: halt with fpc held.
        w_state_nxt = ST_FAULT;
        w_fault_nxt = 1'b1;
      end else if ((r_count < c_DEPTH_CNT) || w_pop) begin
        w_push    = 1'b1;
        w_fpc_nxt = r_fpc + 32'd4;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State, PC and queue registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_fpc   <= RESET_PC;
      r_fault <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q_pc[i]   <= 32'd0;
        r_q_inst[i] <= 32'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_fault <= w_fault_nxt;
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_q_pc[r_tail]   <= r_fpc;
          r_q_inst[r_tail] <= imem_inst;
          r_tail           <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  assign imem_pc     = r_fpc;
  assign out_valid   = (r_count != '0);
  assign out_inst    = r_q_inst[r_head];
  assign out_pc      = r_q_pc[r_head];
  assign fetch_fault = r_fault;
  assign q_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_controller
//  Description : Self-checking bench for fetch_controller. A queue-based
//                reference model tracks the expected fetch PC, queue contents
//                and fault flag; directed scenarios pin key cycles with literal
//                values, followed by a randomized redirect/trap/ready phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  localparam int unsigned c_DEPTH = 4;
  localparam int unsigned c_MEMB  = 1024;
  localparam logic [31:0] c_TRAP  = 32'd700;

  logic        clk;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fetch_fault;
  logic [2:0]  q_count;

  logic [31:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  fetch_controller #(
    .DEPTH     (c_DEPTH),
    .RESET_PC  (32'd0),
    .TRAP_VEC  (c_TRAP),
    .MEM_BYTES (c_MEMB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault),
    .q_count        (q_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_inst = (imem_pc < c_MEMB) ? mem[imem_pc[9:2]] : 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: queue of {pc, inst} entries, fetch PC, fault flag.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic        m_fault;
  int          m_sz;
  bit          m_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < c_MEMB) ? mem[a[9:2]] : 32'h0;
  endfunction

  function automatic bit past_end(input logic [31:0] a);
    return ({32'd0, a} + 64'd4) > 64'(c_MEMB);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_fpc   = 32'd0;
      m_fault = 1'b0;
    end else if (trap_valid) begin
      mq.delete();
      m_fpc   = c_TRAP;
      m_fault = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      m_fpc   = redirect_pc;
      m_fault = (redirect_pc % 4 != 0) || past_end(redirect_pc);
    end else begin
      m_sz  = mq.size();
      m_pop = (m_sz > 0) && out_ready;
      if (m_pop) void'(mq.pop_front());
      if (!m_fault) begin
        if (past_end(m_fpc)) begin
          m_fault = 1'b1;
        end else if (m_sz < int'(c_DEPTH) || m_pop) begin
          mq.push_back('{pc: m_fpc, inst: mem_word(m_fpc)});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("imem_pc", imem_pc, m_fpc);
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
    if (out_valid && mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus: directed scenarios with literal expectations, then random.
  // --------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0]   = 32'h00A00093;
    mem[1]   = 32'h025080B3;
    mem[175] = 32'h00201F73;  // byte 700 (trap vector)
    mem[195] = 32'h00201F73;  // byte 780

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    trap_valid     = 1'b0;
    out_ready      = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_imem_pc", imem_pc, 32'd0);

    // Streaming with decode always ready
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_pc0", out_pc, 32'd0);
    chk("s1_inst0", out_inst, 32'h00A00093);
    @(negedge clk);
    chk("s1_pc4", out_pc, 32'd4);
    chk("s1_inst4", out_inst, 32'h025080B3);

    // Back-pressure fills the queue, then drains without gaps
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("s2_full", 32'(q_count), 32'd4);
    chk("s2_hold_pc", imem_pc, 32'd16);
    chk("s2_head", out_pc, 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("s2_drain_pc", out_pc, 32'(4 * i));
    end

    // Redirect with a full queue
    out_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("s3_full", 32'(q_count), 32'd4);
    redirect_valid = 1'b1; redirect_pc = 32'd780;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("s3_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("s3_flush_count", 32'(q_count), 32'd0);
    @(negedge clk);
    chk("s3_pc", out_pc, 32'd780);
    chk("s3_inst", out_inst, 32'h00201F73);

    // Trap beats simultaneous redirect
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd40;
    @(negedge clk);
    trap_valid = 1'b0; redirect_valid = 1'b0;
    chk("s4_flush_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("s4_pc", out_pc, 32'd700);
    chk("s4_inst", out_inst, 32'h00201F73);

    // Running off the end of memory
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'd1016;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("s5_pc1016", out_pc, 32'd1016);
    @(negedge clk);
    chk("s5_pc1020", out_pc, 32'd1020);
    chk("s5_nofault", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    chk("s5_fault", {31'd0, fetch_fault}, 32'd1);
    repeat (3) @(negedge clk);
    chk("s5_nopush", 32'(q_count), 32'd0);
    chk("s5_sticky", {31'd0, fetch_fault}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("s5_clear", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    chk("s5_resume", out_pc, 32'd0);

    // Misaligned redirect, then reset with a full queue
    redirect_valid = 1'b1; redirect_pc = 32'd2;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("s6_misalign", {31'd0, fetch_fault}, 32'd1);
    chk("s6_empty", 32'(q_count), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("s6_full", 32'(q_count), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s6_rst_count", 32'(q_count), 32'd0);
    chk("s6_rst_pc", imem_pc, 32'd0);
    chk("s6_rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("s6_rst_inst", out_inst, 32'd0);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 299) == 0);
      trap_valid     = ($urandom_range(0, 49) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      out_ready      = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 4))
        0: redirect_pc = 32'($urandom_range(0, 255)) << 2;
        1: redirect_pc = 32'd1012 + (32'($urandom_range(0, 3)) << 2);
        2: redirect_pc = (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(1, 3));
        3: redirect_pc = 32'hFFFF_FFFC;
        default: redirect_pc = 32'd700;
      endcase
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the byte-addressed instruction memory. Holds the fetch PC, drives the memory's `pc` input, captures the returned 32-bit word together with its PC into a small in-order instruction queue, and hands instructions to decode over a valid/ready handshake. Accepts branch/jump redirects and trap entry, which flush the queue. Flags fetches that would run past the end of memory or use a misaligned target.

Parameters:
DEPTH, 4, instruction queue entries (power of two, >=2)
RESET_PC, 0, fetch PC after reset
TRAP_VEC, 700, byte address fetched after trap_valid
MEM_BYTES, 1024, instruction memory size in bytes

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
imem_pc  out  32  byte address to instruction memory; equals internal fetch PC
imem_inst  in  32  word at imem_pc; combinational, valid in the same cycle
redirect_valid  in  1  branch/jump resolved taken; load redirect_pc
redirect_pc  in  32  redirect target byte address
trap_valid  in  1  trap entry; fetch restarts at TRAP_VEC
out_valid  out  1  queue head holds an instruction
out_ready  in  1  decode accepts head this cycle
out_inst  out  32  instruction at queue head
out_pc  out  32  PC of out_inst
fetch_fault  out  1  sticky; fetch halted on out-of-range or misaligned PC
q_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (sync, highest priority) sets: fpc=RESET_PC, head=tail=count=0, state=RUN, fetch_fault=0.
- After reset: out_valid=0, out_inst=0, out_pc=0. The queue is read from registered storage; storage is cleared on reset.
- States:
  - RUN: fetch enabled.
  - FAULT: no pushes; queued entries still drain.
- Control priority each cycle: reset > trap_valid > redirect_valid > normal fetch.
- pop = out_valid & out_ready.
- push = state==RUN & no trap/redirect this cycle & fpc+4 <= MEM_BYTES & (count<DEPTH | pop).
- On push:
  - Write {fpc, imem_inst} at tail.
  - tail++ (wraps modulo DEPTH).
  - fpc += 4.
- Push and pop in the same cycle leave count unchanged. This is legal when full.
- Full with no pop: no push; fpc and imem_pc hold.
- Latency: a word fetched in cycle N appears on out_* in cycle N+1 (queue empty case).
- Range check in RUN with no trap/redirect: if fpc+4 > MEM_BYTES, go to FAULT and set fetch_fault=1. fpc holds.
- trap_valid:
  - Flush the queue: head=tail=count=0.
  - fpc=TRAP_VEC, state=RUN, fetch_fault=0.
  - No push or pop that cycle.
  - out_valid=0 the next cycle; the first trap-vector instruction is visible two cycles after trap_valid.
- redirect_valid (without trap):
  - Same flush as trap, with fpc=redirect_pc.
  - If redirect_pc[1:0]!=0 or redirect_pc+4>MEM_BYTES: state=FAULT, fetch_fault=1, fpc=redirect_pc.
- A pop in the same cycle as a flush is discarded; the consumer must ignore it. Decode only relies on handshakes when redirect_valid=0 and trap_valid=0.
- FAULT is left only by trap, redirect, or reset.
- Arithmetic:
  - fpc is 32-bit unsigned.
  - Range comparisons are done in 33 bits so fpc near 2^32 cannot wrap.
- out_inst and out_pc are stable while out_valid=1 and out_ready=0.

Test Plan:
1. Reset, then program 0x00A00093, 0x025080B3 ... at 0..43, out_ready=1 → out_valid rises cycle 1; out_pc = 0, 4, 8, ... one per cycle; out_inst matches memory order.
2. out_ready=0 for 8 cycles, DEPTH=4 → q_count saturates at 4; imem_pc holds at 16. Then ready=1 → out_pc 0, 4, 8, 12, 16, ... with no gaps or duplicates.
3. Queue full, redirect_valid=1 with redirect_pc=780 → next cycle out_valid=0 and q_count=0; the following cycle out_pc=780, out_inst=0x00201F73.
4. trap_valid and redirect_valid (pc=40) in the same cycle → trap wins; first out_pc=700, out_inst=0x00201F73.
5. Redirect to 1016 → entries at 1016 and 1020 delivered, then fetch_fault=1 and no further pushes. Redirect to 0 clears fetch_fault and fetching resumes.
6. Redirect to 0x2 → fetch_fault=1 immediately, queue empty. Assert reset mid-stream with a full queue → next cycle q_count=0, imem_pc=0, fetch_fault=0.
